// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loader_state_e  : loader FSM encoding
//   BYTES_PER_WORD  : stream bytes packed into one instruction word
//   WORD_ADDR_SHIFT : word index -> byte address shift
package mips_pkg;
  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    CKSUM,
    DONE,
    ERR
  } loader_state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;
endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot loader bus: inbound byte stream (valid/ready) plus outbound
// instruction-memory write port.
//   master : host / memory side (drives stream, observes writes)
//   slave  : loader side (accepts stream, drives writes)
interface imem_boot_loader_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// word_packer: big-endian byte-to-word packer.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear (load restart)
//   byte_vld   : byte accepted this cycle
//   byte_in    : accepted byte
//   last_byte  : next accepted byte completes a word
//   word_valid : one-cycle pulse, the cycle after the 4th byte
//   word       : completed word, held until the next one completes
module word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  byte_cnt;
  logic [23:0] sh;

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= '0;
      sh         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clr) begin
      byte_cnt   <= '0;
      sh         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= byte_vld & last_byte;
      if (byte_vld) begin
        byte_cnt <= byte_cnt + 2'd1;
        sh       <= {sh[15:0], byte_in};
        // Capture the full word separately so imem_wdata stays stable
        // while the next word's bytes shift in.
        if (last_byte) word <= {sh, byte_in};
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-stream program image into instruction
// memory and holds the CPU pipeline in reset until the image is complete.
// Stream: COUNT[15:8], COUNT[7:0], then COUNT big-endian 32-bit words.
// Optional feature macro: BOOT_CHECKSUM_EN (trailing XOR byte over data).
//   clk, rst     : clock, async active-high reset
//   start        : restart a load from DONE or ERR
//   bus (slave)  : in_valid/in_data/in_ready stream, imem_we/addr/wdata writes
//   cpu_rst_hold : high until the image is loaded
//   done, error  : load status levels
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_boot_loader_if.slave  bus,
  output logic               cpu_rst_hold,
  output logic               done,
  output logic               error
);
  loader_state_e     state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  word_idx;
  logic [CNT_W-1:0]  hdr_count;
  logic [ADDR_W-1:0] addr_q;
  logic              xfer, data_xfer, restart, last_word;
  logic              last_byte, word_valid;
  logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        cksum;
`endif

  assign bus.in_ready = ~rst & (state != DONE) & (state != ERR);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign data_xfer    = xfer & (state == DATA);
  assign restart      = start & ((state == DONE) | (state == ERR));
  // Full header value as it will look once the low byte lands.
  assign hdr_count    = {count[CNT_W-1:8], bus.in_data};
  assign last_word    = ((word_idx + CNT_W'(1)) == count);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .byte_vld   (data_xfer),
    .byte_in    (bus.in_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR_HI;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_HI: if (xfer) state_nxt = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (hdr_count == '0)                    state_nxt = DONE;
          else if (hdr_count > CNT_W'(DEPTH))     state_nxt = ERR;
          else                                    state_nxt = DATA;
        end
      end
      DATA: begin
        if (data_xfer && last_byte && last_word)
`ifdef BOOT_CHECKSUM_EN
          state_nxt = CKSUM;
`else
          state_nxt = DONE;
`endif
      end
      CKSUM: begin
`ifdef BOOT_CHECKSUM_EN
        if (xfer) state_nxt = (bus.in_data == cksum) ? DONE : ERR;
`else
        state_nxt = ERR;
`endif
      end
      DONE, ERR: if (start) state_nxt = HDR_HI;
      default:   state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      word_idx <= '0;
      addr_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      cksum    <= '0;
`endif
    end else if (restart) begin
      count    <= '0;
      word_idx <= '0;
      addr_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
      cksum    <= '0;
`endif
    end else if (xfer) begin
      case (state)
        HDR_HI: count <= CNT_W'(bus.in_data) << 8;
        HDR_LO: count <= hdr_count;
        DATA: begin
`ifdef BOOT_CHECKSUM_EN
          cksum <= cksum ^ bus.in_data;
`endif
          // Address registered alongside the packed word so both appear
          // with the write strobe.
          if (last_byte) begin
            addr_q   <= ADDR_W'(word_idx) << WORD_ADDR_SHIFT;
            word_idx <= word_idx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;

  // The FSM enters DONE together with the final write strobe; release the
  // pipeline only once that write has landed.
  assign done         = (state == DONE) & ~word_valid;
  assign error        = (state == ERR);
  assign cpu_rst_hold = ~done;
endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst_hold, done, error;

  int total = 0;
  int bad   = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  logic [7:0] stream [10] = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00,
                              8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] ck_next;
  localparam logic [7:0] CK_GOOD = 8'h8C ^ 8'h01 ^ 8'h00 ^ 8'h04 ^
                                   8'h00 ^ 8'h22 ^ 8'h18 ^ 8'h20;
`endif

  imem_boot_loader_if #(.ADDR_W(32)) bus ();

  imem_boot_loader #(.DEPTH(256), .ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_rst_hold (cpu_rst_hold),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    chk("in_ready_before_send", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_stream(input int gap);
    for (int i = 0; i < 10; i++) send(stream[i], gap);
`ifdef BOOT_CHECKSUM_EN
    send(ck_next, gap);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'h0000_0000);
      chk({tag, "_d0"}, wd[0], 32'h8C01_0004);
      chk({tag, "_a1"}, wa[1], 32'h0000_0004);
      chk({tag, "_d1"}, wd[1], 32'h0022_1820);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
`ifdef BOOT_CHECKSUM_EN
    ck_next = CK_GOOD;
`endif
    repeat (2) @(negedge clk);
    chk("rst_hold", cpu_rst_hold, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_we", bus.imem_we, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_wdata", bus.imem_wdata, 32'h0);
    chk("rst_ready", bus.in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 6; i++) send(stream[i], 0);
    chk("w0_we", bus.imem_we, 1'b1);
    chk("w0_addr", bus.imem_addr, 32'h0);
    chk("w0_data", bus.imem_wdata, 32'h8C01_0004);
    chk("w0_hold", cpu_rst_hold, 1'b1);
    send(stream[6], 0);
    chk("w0_strobe_1cyc", bus.imem_we, 1'b0);
    for (int i = 7; i < 10; i++) send(stream[i], 0);
    chk("w1_we", bus.imem_we, 1'b1);
    chk("w1_addr", bus.imem_addr, 32'h4);
    chk("w1_data", bus.imem_wdata, 32'h0022_1820);
    chk("w1_done_not_yet", done, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    send(CK_GOOD, 0);
`endif
    @(negedge clk);
    chk("t2_done", done, 1'b1);
    chk("t2_hold", cpu_rst_hold, 1'b0);
    chk("t2_ready", bus.in_ready, 1'b0);
    check_writes("t2");

    start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0;
    chk("restart_done", done, 1'b0);
    chk("restart_hold", cpu_rst_hold, 1'b1);
    chk("restart_ready", bus.in_ready, 1'b1);

    send(8'h00, 0);
    send(8'h00, 0);
    chk("t3_done", done, 1'b1);
    chk("t3_err", error, 1'b0);
    chk("t3_nwr", wa.size(), 2);

    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    chk("t4_err", error, 1'b1);
    chk("t4_ready", bus.in_ready, 1'b0);
    chk("t4_hold", cpu_rst_hold, 1'b1);
    chk("t4_done", done, 1'b0);
    chk("t4_nwr", wa.size(), 2);
    pulse_start();
    chk("t4_restart_err", error, 1'b0);
    chk("t4_restart_ready", bus.in_ready, 1'b1);

    wa.delete(); wd.delete();
    send_stream(3);
    @(negedge clk);
    chk("t5_done", done, 1'b1);
    check_writes("t5");

    pulse_start();
    wa.delete(); wd.delete();
    for (int i = 0; i < 5; i++) send(stream[i], 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", bus.in_ready, 1'b0);
    chk("t6_rst_hold", cpu_rst_hold, 1'b1);
    chk("t6_rst_wdata", bus.imem_wdata, 32'h0);
    chk("t6_rst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_nwr_partial", wa.size(), 0);
    send_stream(0);
    @(negedge clk);
    chk("t6_done", done, 1'b1);
    chk("t6_hold", cpu_rst_hold, 1'b0);
    check_writes("t6");

`ifdef BOOT_CHECKSUM_EN
    pulse_start();
    wa.delete(); wd.delete();
    ck_next = 8'h00;
    send_stream(0);
    @(negedge clk);
    chk("ck_bad_err", error, 1'b1);
    chk("ck_bad_done", done, 1'b0);
    check_writes("ck_bad");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
